uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx_8n1 among NREQ byte producers.
// Ports: clk, resetn (async low); req_valid/req_data/req_ready per requester;
// tx_byte/tx_send/tx_done to the transmitter; busy, grant_id, timeout status.
// Optional macro UART_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_byte,
    output logic                    tx_send,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    timeout
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gid_q, gid_d;
    logic [7:0]      byte_q, byte_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic            send_q, send_d;
    logic            busy_q, busy_d;
    logic            to_q, to_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Search starts one past the last winner and wraps, so the last
    // winner has the lowest priority next time.
    always_comb begin
        logic [IDW-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        byte_d  = byte_q;
        ready_d = '0;
        send_d  = 1'b0;
        to_d    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    byte_d           = req_data[8*win_idx +: 8];
                    gid_d            = win_idx;
                    ptr_d            = win_idx;
                    ready_d[win_idx] = 1'b1;
                    send_d           = 1'b1;
                    state_d          = S_SEND;
                end
            end
            S_SEND: begin
                // tx_done here is dropped on purpose.
                state_d = S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (tx_done) begin
                    state_d = S_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            gid_q   <= '0;
            byte_q  <= '0;
            ready_q <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign tx_byte   = byte_q;
    assign tx_send   = send_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;
    assign timeout   = to_q;

endmodule
